mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch waits.
REQ-002 SHALL have port clk  in  1  main clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port if_req  in  1  instruction fetch request, held until if_ack.
REQ-005 SHALL have port if_addr  in  32  fetch address.
REQ-006 SHALL have ports if_rdata  out  32  and if_ack  out  1  fetch data and one-cycle done pulse.
REQ-007 SHALL have ports d_ren, d_wen  in  1 each  data read and write requests, held until d_ack.
REQ-008 SHALL have ports d_addr, d_wdata  in  32 each  data address and store data.
REQ-009 SHALL have ports d_rdata  out  32  and d_ack  out  1  load data and one-cycle done pulse.
REQ-010 SHALL have ports m_req, m_we  out  1 each and m_addr, m_wdata  out  32 each  shared memory request.
REQ-011 SHALL have ports m_rdata  in  32  and m_ack  in  1  memory data and completion.
REQ-012 SHALL have ports if_stall, mem_stall  out  1 each  stall indications to the pipeline controller.

Function
REQ-013 SHALL implement FSM states IDLE, GNT_I, GNT_D.
REQ-014 In IDLE, SHALL go to GNT_D if d_ren|d_wen, else to GNT_I if if_req, else stay in IDLE.
REQ-015 On entering a grant, SHALL register m_addr, m_wdata and m_we (m_we=1 for data write, else 0) and assert m_req on the next cycle.
REQ-016 In a grant state, SHALL hold m_req and all m_* outputs stable until m_ack=1.
REQ-017 On m_ack, SHALL register m_rdata into the granted requester's rdata, pulse its ack for exactly one cycle, drop m_req, and return to IDLE.
REQ-018 Latency: request at cycle 0 with m_ack at cycle k SHALL produce ack at cycle k+1; the minimum is 3 cycles.
REQ-019 d_ren and d_wen both high SHALL be treated as a write.
REQ-020 if_stall SHALL equal if_req & ~if_ack, and mem_stall SHALL equal (d_ren|d_wen) & ~d_ack, both combinational.
REQ-021 m_ack in IDLE SHALL be ignored.
REQ-022 A requester dropping its request mid-grant SHALL NOT abort the transaction; the ack still pulses.
REQ-023 if_rdata and d_rdata SHALL hold their last captured value until the next completion for that port.

Reset
REQ-024 rst SHALL asynchronously force IDLE and set m_req, m_we, if_ack and d_ack to 0.
REQ-025 rst SHALL asynchronously set m_addr, m_wdata, if_rdata, d_rdata and the starvation count to 0.
REQ-026 Reset mid-grant SHALL abandon the transaction, and an m_ack arriving after reset SHALL have no effect.

Configuration
REQ-027 Macro MEM_ARB_STARVE_EN, when defined, SHALL count consecutive data grants issued while if_req=1.
REQ-028 With MEM_ARB_STARVE_EN defined and the count equal to STARVE_LIMIT, the next IDLE arbitration SHALL grant IF.
REQ-029 With MEM_ARB_STARVE_EN defined, the count SHALL clear on any IF grant or whenever if_req=0.
REQ-030 Without MEM_ARB_STARVE_EN, arbitration SHALL be strict data priority with no counter logic.

Structure
REQ-031 State encodings and the STARVE_LIMIT default SHALL live in shared package mem_arb_pkg.
REQ-032 The starvation counter SHALL be sub-module arb_age_counter, instantiated only under MEM_ARB_STARVE_EN.

Verification
REQ-033 Single fetch: if_req=1 at addr 0x0000_0040, m_ack after 2 cycles with m_rdata=0x2008_0005 -> if_ack pulses once, if_rdata=0x2008_0005, if_stall low after the ack.
REQ-034 Simultaneous requests: if_req and d_ren at cycle 0 -> data served first (m_we=0), then the fetch; d_ack precedes if_ack.
REQ-035 Store: d_wen=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> m_we=1 with that address and data, held stable until m_ack, then d_ack pulses.
REQ-036 Reset: assert rst while m_req=1 in GNT_D -> m_req falls in the same cycle, a later m_ack produces no ack, and the FSM is in IDLE.
REQ-037 Starvation with MEM_ARB_STARVE_EN, STARVE_LIMIT=4: continuous data and fetch requests -> grant order D,D,D,D,I repeating; without the macro -> fetch is never granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/arb_age_counter.sv
// Saturating count of consecutive data grants issued while a fetch is waiting.
module arb_age_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned W = cnt_width(LIMIT);
    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && count_q != LIMIT_V) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit = (count_q == LIMIT_V);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data accesses.
// Define MEM_ARB_STARVE_EN to force a fetch grant after STARVE_LIMIT consecutive data grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        if_stall,
    output logic        mem_stall
);

    arb_state_e  state_q, state_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic d_any;
    logic idle_arb;
    logic pick_i, pick_d;

    assign d_any = d_ren | d_wen;
    // Requesters still hold their request during the ack cycle; arbitrating then would re-serve it.
    assign idle_arb = (state_q == IDLE) && !(if_ack_q || d_ack_q);

`ifdef MEM_ARB_STARVE_EN
    logic starved;

    arb_age_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_age (
        .clk      (clk),
        .rst      (rst),
        .inc      (pick_d & if_req),
        .clr      (pick_i | ~if_req),
        .at_limit (starved)
    );

    assign pick_i = idle_arb & if_req & (~d_any | starved);
    assign pick_d = idle_arb & d_any & ~pick_i;
`else
    assign pick_d = idle_arb & d_any;
    assign pick_i = idle_arb & if_req & ~d_any;
`endif

    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d   = GNT_D;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    m_we_d    = d_wen;
                end else if (pick_i) begin
                    state_d   = GNT_I;
                    m_addr_d  = if_addr;
                    m_wdata_d = '0;
                    m_we_d    = 1'b0;
                end
            end
            GNT_I, GNT_D: begin
                // m_req rises one cycle after the grant; m_ack only counts once it is up.
                if (!m_req_q) begin
                    m_req_d = 1'b1;
                end else if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = IDLE;
                    if (state_q == GNT_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_rdata;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = m_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    starve_limit_nonzero: assert property (@(posedge clk) disable iff (rst) STARVE_LIMIT > 0);

    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign mem_stall = d_any & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model (grant choice, memory latency, ack timing, captured data).
module tb_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_ren, d_wen;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_ack;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_ack;
    logic        if_stall, mem_stall;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .if_stall(if_stall), .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_ren;
        logic        d_wen;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
    } req_t;

    req_t        h1, h2;              // inputs applied one and two samples ago
    int          mode_if, mode_d;     // after ack: 0 drop, 1 random, 2 continuous
    int          mem_delay;           // <0 means random 0..3
    logic [31:0] next_rdata;
    bit          use_next, spurious;
    int          mem_cnt;
    bit          acked, prev_m_req;
    bit          exp_if_ack, exp_d_ack, ack_if_now, ack_d_now;
    logic [31:0] exp_if_rdata, exp_d_rdata;
    bit          tx_d, tx_we;
    logic [31:0] tx_addr, tx_wdata;
    int          cyc;
    int          grants[$];
    int          if_ack_cyc, d_ack_cyc, if_ack_n, d_ack_n;
`ifdef MEM_ARB_STARVE_EN
    int          starve_cnt;
`endif

    task automatic model_reset();
        h1 = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
        h2 = h1;
        mem_cnt = 0; acked = 0; prev_m_req = 0;
        exp_if_ack = 0; exp_d_ack = 0; ack_if_now = 0; ack_d_now = 0;
        exp_if_rdata = '0; exp_d_rdata = '0;
`ifdef MEM_ARB_STARVE_EN
        starve_cnt = 0;
`endif
    endtask

    task automatic cycle();
        req_t cur;
        bit   grant, pick_d, dp, fp;
        logic [3:0] r;
        #1;
        check("if_stall", if_stall, if_req & ~ack_if_now);
        check("mem_stall", mem_stall, (d_ren | d_wen) & ~ack_d_now);
        cur.if_req = if_req; cur.if_addr = if_addr;
        cur.d_ren = d_ren; cur.d_wen = d_wen; cur.d_addr = d_addr; cur.d_wdata = d_wdata;
        h2 = h1;
        h1 = cur;
        @(posedge clk);
        #1;
        cyc++;
        check("if_ack", if_ack, exp_if_ack);
        check("d_ack", d_ack, exp_d_ack);
        check("if_rdata", if_rdata, exp_if_rdata);
        check("d_rdata", d_rdata, exp_d_rdata);
        ack_if_now = exp_if_ack;
        ack_d_now = exp_d_ack;
        exp_if_ack = 0;
        exp_d_ack = 0;
        if (ack_if_now) begin if_ack_n++; if_ack_cyc = cyc; end
        if (ack_d_now) begin d_ack_n++; d_ack_cyc = cyc; end

        // A rising m_req reflects the arbitration made on the inputs of two samples ago.
        grant = m_req && !prev_m_req;
        if (grant) begin
            dp = h2.d_ren | h2.d_wen;
            fp = h2.if_req;
`ifdef MEM_ARB_STARVE_EN
            pick_d = dp && !(fp && starve_cnt >= LIMIT);
`else
            pick_d = dp;
`endif
            check("grant_had_request", 32'(dp | fp), 1);
            tx_d = pick_d;
            tx_addr = pick_d ? h2.d_addr : h2.if_addr;
            tx_we = pick_d && h2.d_wen;
            tx_wdata = m_wdata;
            grants.push_back(pick_d);
            check("m_addr", m_addr, tx_addr);
            check("m_we", m_we, tx_we);
            if (tx_we) check("m_wdata", m_wdata, h2.d_wdata);
            mem_cnt = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
        end else if (m_req) begin
            check("m_addr_hold", m_addr, tx_addr);
            check("m_we_hold", m_we, tx_we);
            check("m_wdata_hold", m_wdata, tx_wdata);
        end
`ifdef MEM_ARB_STARVE_EN
        if (!h2.if_req || (grant && !tx_d)) starve_cnt = 0;
        else if (grant && tx_d && starve_cnt < LIMIT) starve_cnt++;
`endif

        if (m_req && !acked && mem_cnt == 0) begin
            m_ack = 1'b1;
            m_rdata = use_next ? next_rdata : $urandom;
            use_next = 0;
            acked = 1;
            if (tx_d) begin exp_d_ack = 1; exp_d_rdata = m_rdata; end
            else begin exp_if_ack = 1; exp_if_rdata = m_rdata; end
        end else begin
            m_ack = (spurious && !m_req) ? 1'($urandom_range(0, 1)) : 1'b0;
            m_rdata = $urandom;
            if (m_req && mem_cnt > 0) mem_cnt--;
        end
        if (!m_req) acked = 0;
        prev_m_req = m_req;

        if (ack_if_now) begin
            case (mode_if)
                1: begin if_req = 1'($urandom_range(0, 1)); if_addr = $urandom; end
                2: if_addr = if_addr + 32'd4;
                default: if_req = 1'b0;
            endcase
        end else if (mode_if == 1 && !if_req && $urandom_range(0, 3) == 0) begin
            if_req = 1'b1; if_addr = $urandom;
        end
        if (ack_d_now) begin
            case (mode_d)
                1: begin
                    r = 4'($urandom);
                    d_ren = r[0]; d_wen = r[1]; d_addr = $urandom; d_wdata = $urandom;
                end
                2: d_addr = d_addr + 32'd4;
                default: begin d_ren = 1'b0; d_wen = 1'b0; end
            endcase
        end else if (mode_d == 1 && !(d_ren || d_wen) && $urandom_range(0, 3) == 0) begin
            r = 4'($urandom);
            d_ren = r[0] | ~r[1]; d_wen = r[1]; d_addr = $urandom; d_wdata = $urandom;
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        mode_if = 0;
        mode_d = 0;
        while ((if_req || d_ren || d_wen || m_req || exp_if_ack || exp_d_ack) && n < max) begin
            cycle();
            n++;
        end
        check("drain_timeout", 32'(n < max), 1);
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req = 0; if_addr = '0; d_ren = 0; d_wen = 0; d_addr = '0; d_wdata = '0;
        m_ack = 0; m_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_req", m_req, 0);
        check("rst_m_we", m_we, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_acks", {if_ack, d_ack}, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_m_req(input int max);
        for (int i = 0; i < max && !m_req; i++) cycle();
        check("wait_m_req", m_req, 1);
    endtask

    initial begin
        int start, n0, exp_g;
        mode_if = 0; mode_d = 0; mem_delay = 0; use_next = 0; spurious = 0;
        cyc = 0; if_ack_n = 0; d_ack_n = 0; if_ack_cyc = 0; d_ack_cyc = 0;
        do_reset();

        // Single fetch, memory answers two cycles after m_req.
        mem_delay = 2; use_next = 1; next_rdata = 32'h2008_0005;
        start = cyc; n0 = if_ack_n;
        if_req = 1; if_addr = 32'h0000_0040;
        drain(30);
        check("fetch_ack_count", if_ack_n - n0, 1);
        check("fetch_latency", if_ack_cyc - start, 5);
        check("fetch_rdata", if_rdata, 32'h2008_0005);

        // Minimum latency: data read with immediate m_ack.
        mem_delay = 0;
        start = cyc;
        d_ren = 1; d_addr = 32'h0000_0200;
        drain(30);
        check("min_latency", d_ack_cyc - start, 3);

        // Simultaneous fetch and load: data first.
        grants.delete();
        mem_delay = 1;
        if_req = 1; if_addr = 32'h0000_1000; d_ren = 1; d_addr = 32'h0000_2000;
        drain(60);
        check("simul_grants", grants.size(), 2);
        if (grants.size() == 2) begin
            check("simul_first_is_d", grants[0], 1);
            check("simul_second_is_i", grants[1], 0);
        end
        check("simul_d_before_i", 32'(d_ack_cyc < if_ack_cyc), 1);

        // Store held stable for several cycles.
        mem_delay = 3;
        d_wen = 1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        wait_m_req(10);
        check("store_m_we", m_we, 1);
        check("store_m_addr", m_addr, 32'h0000_0100);
        check("store_m_wdata", m_wdata, 32'hDEAD_BEEF);
        drain(30);

        // Read and write together count as a write.
        d_ren = 1; d_wen = 1; d_addr = 32'h0000_0300; d_wdata = 32'h1234_5678;
        wait_m_req(10);
        check("rw_is_write", m_we, 1);
        drain(30);

        // Fetch dropped mid-grant still completes.
        n0 = if_ack_n;
        if_req = 1; if_addr = 32'h0000_0080;
        wait_m_req(10);
        if_req = 0;
        drain(30);
        check("drop_still_acks", if_ack_n - n0, 1);

        // Reset in the middle of a data grant.
        mem_delay = 20;
        d_ren = 1; d_addr = 32'h0000_0400;
        wait_m_req(10);
        #3 rst = 1'b1;
        #1;
        check("rst_mid_m_req", m_req, 0);
        d_ren = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_ack = 1; m_rdata = 32'hBAD0_0000 + 32'(i);
            @(posedge clk);
            #1;
            check("late_ack_none", {if_ack, d_ack}, 0);
            check("late_ack_m_req", m_req, 0);
            check("late_ack_d_rdata", d_rdata, 0);
        end
        m_ack = 0;
        model_reset();
        mem_delay = 0;
        n0 = if_ack_n;
        if_req = 1; if_addr = 32'h0000_0500;
        drain(30);
        check("after_rst_fetch", if_ack_n - n0, 1);

        // Continuous fetch and data traffic.
        grants.delete();
        mem_delay = 0; mode_if = 2; mode_d = 2;
        if_req = 1; if_addr = 32'h0000_6000; d_ren = 1; d_addr = 32'h0000_7000;
        for (int i = 0; i < 300 && grants.size() < 15; i++) cycle();
        check("starve_grants", 32'(grants.size() >= 15), 1);
        for (int i = 0; i < 15 && i < grants.size(); i++) begin
`ifdef MEM_ARB_STARVE_EN
            exp_g = (i % 5 == 4) ? 0 : 1;
`else
            exp_g = 1;
`endif
            check($sformatf("starve_order_%0d", i), grants[i], exp_g);
        end
        drain(100);

        // Random traffic.
        mem_delay = -1; mode_if = 1; mode_d = 1;
        for (int i = 0; i < 600; i++) cycle();
        drain(200);

        // Spurious m_ack while idle.
        spurious = 1;
        repeat (12) cycle();
        spurious = 0;
        m_ack = 0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
